// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, state encoding and decode helpers for the cache controller
package cache_pkg;

    localparam int NUM_WAYS = 2;
    localparam int NUM_SETS = 4;
    localparam int IDX_W    = 2;
    localparam int WAY_W    = 1;
    localparam int BEATS    = 4;
    localparam int BEAT_W   = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TAG  = 3'd1,
        DATA = 3'd2,
        WB   = 3'd3,
        FILL = 3'd4,
        LOAD = 3'd5
    } state_t;

    // Set index to one-hot row select for the arrays.
    function automatic logic [NUM_SETS-1:0] index_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SETS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Way number to one-hot per-way strobe.
    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
        logic [NUM_WAYS-1:0] v;
        v      = '0;
        v[way] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// rtl/cache_ctrl_fsm_if.sv - CPU, array and memory signals of the cache controller
interface cache_ctrl_fsm_if;

    logic                           cpu_req;
    logic                           cpu_rw;
    logic [cache_pkg::IDX_W-1:0]    cpu_index;
    logic [cache_pkg::NUM_WAYS-1:0] hit;
    logic [cache_pkg::NUM_WAYS-1:0] dirty;
    logic                           lru_way;
    logic                           mem_ack;

    logic                           busy;
    logic                           cpu_done;
    logic                           cycle_en;
    logic                           rw;
    logic [cache_pkg::NUM_WAYS-1:0] load;
    logic [cache_pkg::NUM_WAYS-1:0] way_sel;
    logic [cache_pkg::NUM_SETS-1:0] index_dec;
    logic                           mem_rd;
    logic                           mem_wr;
    logic [cache_pkg::BEAT_W-1:0]   beat_cnt;
    logic                           victim;

    // Controller side.
    modport master (
        input  cpu_req, cpu_rw, cpu_index, hit, dirty, lru_way, mem_ack,
        output busy, cpu_done, cycle_en, rw, load, way_sel, index_dec,
               mem_rd, mem_wr, beat_cnt, victim
    );

    // CPU / array / memory side.
    modport slave (
        output cpu_req, cpu_rw, cpu_index, hit, dirty, lru_way, mem_ack,
        input  busy, cpu_done, cycle_en, rw, load, way_sel, index_dec,
               mem_rd, mem_wr, beat_cnt, victim
    );

endinterface

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - beat counter shared by the writeback and fill bursts
module burst_counter
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [BEAT_W-1:0] cnt,
    output logic              last
);

    assign last = (cnt == BEAT_W'(BEATS - 1));

    // Advance on each accepted beat; the final beat wraps to 0 for the next burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - sequencing controller for the phased 2-way write-back cache
module cache_ctrl_fsm
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    cache_ctrl_fsm_if.master bus
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic               rw_q, rw_nxt;
    logic [WAY_W-1:0]   victim_q, victim_nxt;
    logic [WAY_W-1:0]   hit_way_q, hit_way_nxt;

    logic               beat_en;
    logic               beat_last;
    logic [BEAT_W-1:0]  beat_cnt;

    logic                busy_d, cpu_done_d, cycle_en_d, rw_d, mem_rd_d, mem_wr_d;
    logic [NUM_WAYS-1:0] load_d, way_sel_d;
    logic [NUM_SETS-1:0] index_dec_d;

    // Acks only count while a burst is actually in flight.
    assign beat_en = bus.mem_ack && ((state == WB) || (state == FILL));

    burst_counter u_burst_counter (
        .clk   (clk),
        .reset (reset),
        .en    (beat_en),
        .cnt   (beat_cnt),
        .last  (beat_last)
    );

    // State register and the request/lookup values latched alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            victim_q  <= '0;
            hit_way_q <= '0;
        end else begin
            state     <= state_nxt;
            idx_q     <= idx_nxt;
            rw_q      <= rw_nxt;
            victim_q  <= victim_nxt;
            hit_way_q <= hit_way_nxt;
        end
    end

    // Next-state logic: lookup, optional writeback, fill, load, then replay the lookup.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx_q;
        rw_nxt      = rw_q;
        victim_nxt  = victim_q;
        hit_way_nxt = hit_way_q;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    idx_nxt   = bus.cpu_index;
                    rw_nxt    = bus.cpu_rw;
                    state_nxt = TAG;
                end
            end
            TAG: begin
                if (|bus.hit) begin
                    // Scan high to low so the lowest matching way is the one kept.
                    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                        if (bus.hit[w]) begin
                            hit_way_nxt = WAY_W'(w);
                        end
                    end
                    state_nxt = DATA;
                end else begin
                    victim_nxt = bus.lru_way;
                    state_nxt  = bus.dirty[bus.lru_way] ? WB : FILL;
                end
            end
            DATA: begin
                state_nxt = IDLE;
            end
            WB: begin
                if (beat_en && beat_last) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (beat_en && beat_last) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = TAG;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobe values for the state being entered, so every output comes straight from a flop.
    always_comb begin
        busy_d      = (state_nxt != IDLE);
        cpu_done_d  = (state_nxt == DATA);
        cycle_en_d  = (state_nxt == DATA) || (state_nxt == LOAD);
        rw_d        = (state_nxt == DATA) && rw_nxt;
        mem_rd_d    = (state_nxt == FILL);
        mem_wr_d    = (state_nxt == WB);
        load_d      = (state_nxt == LOAD) ? way_onehot(victim_nxt) : '0;
        way_sel_d   = (state_nxt == DATA) ? way_onehot(hit_way_nxt) : '0;
        index_dec_d = (state_nxt != IDLE) ? index_onehot(idx_nxt) : '0;
    end

    // Output registers; reset clears them at once, which also aborts any burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.busy      <= 1'b0;
            bus.cpu_done  <= 1'b0;
            bus.cycle_en  <= 1'b0;
            bus.rw        <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.load      <= '0;
            bus.way_sel   <= '0;
            bus.index_dec <= '0;
        end else begin
            bus.busy      <= busy_d;
            bus.cpu_done  <= cpu_done_d;
            bus.cycle_en  <= cycle_en_d;
            bus.rw        <= rw_d;
            bus.mem_rd    <= mem_rd_d;
            bus.mem_wr    <= mem_wr_d;
            bus.load      <= load_d;
            bus.way_sel   <= way_sel_d;
            bus.index_dec <= index_dec_d;
        end
    end

    assign bus.beat_cnt = beat_cnt;
    assign bus.victim   = victim_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - randomized self-checking bench for cache_ctrl_fsm
module tb_cache_ctrl_fsm;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_ctrl_fsm_if bus ();

    cache_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit       busy, done, cyc, rw;
        bit [1:0] load, way_sel;
        bit [3:0] idx_dec;
        bit       rd, wr;
        bit [1:0] beat;
        bit       victim;
        bit       ack;
        bit       replay;
    } cyc_t;

    cyc_t exp_q[$];
    int   forced_ack[$];
    bit   model_dirty[4][2];
    bit   env_dirty[4][2];
    bit   model_victim;

    function automatic logic [16:0] pack_obs();
        return {bus.busy, bus.cpu_done, bus.cycle_en, bus.rw, bus.load, bus.way_sel,
                bus.index_dec, bus.mem_rd, bus.mem_wr, bus.beat_cnt, bus.victim};
    endfunction

    function automatic logic [16:0] pack_exp(input cyc_t c);
        return {c.busy, c.done, c.cyc, c.rw, c.load, c.way_sel,
                c.idx_dec, c.rd, c.wr, c.beat, c.victim};
    endfunction

    function automatic cyc_t blank(input bit [1:0] idx);
        cyc_t c;
        c         = '{default: 0};
        c.busy    = 1'b1;
        c.idx_dec = 4'b0001 << idx;
        c.victim  = model_victim;
        c.ack     = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic void add_burst(input bit [1:0] idx, input bit is_wr);
        int   beats;
        cyc_t c;
        beats = 0;
        while (beats < BEATS) begin
            c      = blank(idx);
            c.rd   = !is_wr;
            c.wr   = is_wr;
            c.beat = 2'(beats);
            if (forced_ack.size() > 0) c.ack = 1'(forced_ack.pop_front());
            else                       c.ack = ($urandom_range(0, 3) != 0);
            if (c.ack) beats++;
            exp_q.push_back(c);
        end
    endfunction

    // Transaction-level model: lays out the expected cycle sequence of one access.
    function automatic void build(input bit [1:0] idx, input bit rw, input bit [1:0] hit_pat, input bit lru);
        cyc_t c;
        bit   hw;
        exp_q.delete();
        exp_q.push_back(blank(idx));
        if (hit_pat != 0) begin
            hw = hit_pat[0] ? 1'b0 : 1'b1;
        end else begin
            model_victim = lru;
            if (model_dirty[idx][lru]) add_burst(idx, 1'b1);
            add_burst(idx, 1'b0);
            c      = blank(idx);
            c.cyc  = 1'b1;
            c.load = 2'b01 << lru;
            exp_q.push_back(c);
            model_dirty[idx][lru] = 1'b0;
            c        = blank(idx);
            c.replay = 1'b1;
            exp_q.push_back(c);
            hw = lru;
        end
        c         = blank(idx);
        c.done    = 1'b1;
        c.cyc     = 1'b1;
        c.rw      = rw;
        c.way_sel = 2'b01 << hw;
        exp_q.push_back(c);
        if (rw) model_dirty[idx][hw] = 1'b1;
    endfunction

    task automatic check_idle(input string name);
        cyc_t c;
        c        = '{default: 0};
        c.victim = model_victim;
        check({name, " idle"}, 32'(pack_obs()), 32'(pack_exp(c)));
    endtask

    task automatic run(input string name, input bit [1:0] idx, input bit rw,
                       input bit [1:0] hit_pat, input bit lru);
        cyc_t c;
        build(idx, rw, hit_pat, lru);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_rw    = rw;
        bus.cpu_index = idx;
        bus.hit       = 2'($urandom);
        bus.lru_way   = 1'($urandom);
        bus.dirty     = {env_dirty[idx][1], env_dirty[idx][0]};
        bus.mem_ack   = 1'($urandom);
        @(posedge clk);
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clk);
            c = exp_q[t];
            check($sformatf("%s c%0d", name, t), 32'(pack_obs()), 32'(pack_exp(c)));
            bus.cpu_req   = 1'($urandom);
            bus.cpu_rw    = 1'($urandom);
            bus.cpu_index = 2'($urandom);
            bus.hit       = c.replay ? (2'b01 << model_victim) : (t == 0 ? hit_pat : 2'($urandom));
            bus.lru_way   = (t == 0) ? lru : 1'($urandom);
            bus.dirty     = {env_dirty[idx][1], env_dirty[idx][0]};
            bus.mem_ack   = c.ack;
            if (bus.cycle_en) begin
                for (int w = 0; w < 2; w++) begin
                    if (bus.load[w])                    env_dirty[idx][w] = 1'b0;
                    else if (bus.rw && bus.way_sel[w])  env_dirty[idx][w] = 1'b1;
                end
            end
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check_idle(name);
        check({name, " dirty"}, 32'({env_dirty[idx][1], env_dirty[idx][0]}),
              32'({model_dirty[idx][1], model_dirty[idx][0]}));
    endtask

    task automatic reset_mid_fill();
        int acks;
        int n;
        acks = 0;
        n    = 0;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_rw    = 1'b0;
        bus.cpu_index = 2'd0;
        bus.hit       = 2'b00;
        bus.lru_way   = 1'b1;
        bus.dirty     = {env_dirty[0][1], env_dirty[0][0]};
        bus.mem_ack   = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            n++;
            if ((bus.mem_rd && acks == 2) || n > 20) break;
            bus.mem_ack = bus.mem_rd;
            if (bus.mem_rd) acks++;
        end
        check("rst pre beat", 32'(bus.beat_cnt), 32'd2);
        check("rst pre rd", 32'(bus.mem_rd), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst beat", 32'(bus.beat_cnt), 32'd0);
        check("rst victim", 32'(bus.victim), 32'd0);
        model_victim = 1'b0;
        bus.mem_ack  = 1'b0;
        #1 reset = 1'b0;
        check("rst dirty0", 32'({env_dirty[0][1], env_dirty[0][0]}),
              32'({model_dirty[0][1], model_dirty[0][0]}));
    endtask

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_rw    = 1'b0;
        bus.cpu_index = '0;
        bus.hit       = '0;
        bus.dirty     = '0;
        bus.lru_way   = 1'b0;
        bus.mem_ack   = 1'b1;
        model_victim  = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                model_dirty[s][w] = 1'b0;
                env_dirty[s][w]   = 1'b0;
            end
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        run("read_hit", 2'd2, 1'b0, 2'b10, 1'b0);
        run("write_hit", 2'd1, 1'b1, 2'b01, 1'b1);
        run("multi_hit", 2'd1, 1'b0, 2'b11, 1'b1);
        repeat (4) forced_ack.push_back(1);
        run("clean_miss", 2'd0, 1'b0, 2'b00, 1'b1);
        run("pre_dirty", 2'd3, 1'b1, 2'b01, 1'b1);
        run("dirty_miss", 2'd3, 1'b1, 2'b00, 1'b0);
        forced_ack = '{1, 0, 0, 1, 1, 0, 1};
        run("fill_stall", 2'd2, 1'b0, 2'b00, 1'b0);
        forced_ack.delete();

        reset_mid_fill();
        run("after_rst", 2'd1, 1'b0, 2'b10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run($sformatf("rnd%0d", i), 2'($urandom), 1'($urandom),
                ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
